// File: rtl/fpu_config_fetch.sv
// fpu_config_fetch: polls a memory-mapped start register, then fetches image
// dimensions, source/result base addresses and a KxK signed 8-bit filter.
// The complete configuration is published in a single cycle and held
// unchanged until the controller reports the job finished.
module fpu_config_fetch #(
   parameter int unsigned FILTER_DIM     = 3,
   parameter logic [31:0] STARTSIG_ADDR  = 32'h1000_0120,
   parameter logic [31:0] DIMS_ADDR      = 32'h1000_0000,
   parameter logic [31:0] SRC_ADDR       = 32'h1000_0020,
   parameter logic [31:0] FILTER_ADDR    = 32'h1000_0040,
   parameter logic [31:0] RESULT_ADDR    = 32'h1000_0100,
   parameter int unsigned TIMEOUT_CYCLES = 1024
) (
   input  logic                                 clk,
   input  logic                                 rst,
   output logic [31:0]                          mapped_address,
   input  logic [31:0]                          mapped_data,
   input  logic                                 mapped_data_valid,
   input  logic                                 job_done,
   output logic [15:0]                          image_width,
   output logic [15:0]                          image_height,
   output logic [31:0]                          start_address,
   output logic [31:0]                          result_address,
   output logic [8*FILTER_DIM*FILTER_DIM-1:0]   filter,
   output logic                                 load_config_done,
   output logic                                 busy,
   output logic                                 err_timeout,
   output logic                                 err_dims
);

   localparam int unsigned NT = FILTER_DIM * FILTER_DIM;
   localparam int unsigned NW = (NT + 3) / 4;
   localparam int unsigned WW = $clog2(NW);
   localparam int unsigned CW = $clog2(TIMEOUT_CYCLES);

   localparam logic [2:0] POLL  = 3'd0;
   localparam logic [2:0] DIMS  = 3'd1;
   localparam logic [2:0] SRC   = 3'd2;
   localparam logic [2:0] RES   = 3'd3;
   localparam logic [2:0] FILT  = 3'd4;
   localparam logic [2:0] DONE  = 3'd5;
   localparam logic [2:0] RUN   = 3'd6;
   localparam logic [2:0] CLEAR = 3'd7;

   logic [2:0]      state;
   logic [CW-1:0]   cnt;
   logic [WW-1:0]   w;
   logic [15:0]     sh_width;
   logic [15:0]     sh_height;
   logic [31:0]     sh_src;
   logic [31:0]     sh_res;
   logic [8*NT-1:0] sh_filt;
   logic            waiting;
   logic            expire;
   logic            last_word;

   assign busy      = (state != POLL);
   assign waiting   = (state != DONE) && (state != RUN);
   assign expire    = waiting && !mapped_data_valid && (cnt == CW'(TIMEOUT_CYCLES - 1));
   assign last_word = (w == WW'(NW - 1));

   // Read timeout counter: restarts on every accepted read (which is also
   // the only time the address moves) and idles outside read-issuing states.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt <= '0;
      end else if (!waiting || mapped_data_valid || expire) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + CW'(1);
      end
   end

   // Fetch sequencer: issues reads, fills the shadow copy, publishes in DONE.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state            <= POLL;
         mapped_address   <= STARTSIG_ADDR;
         w                <= '0;
         sh_width         <= '0;
         sh_height        <= '0;
         sh_src           <= '0;
         sh_res           <= '0;
         sh_filt          <= '0;
         image_width      <= '0;
         image_height     <= '0;
         start_address    <= '0;
         result_address   <= '0;
         filter           <= '0;
         load_config_done <= 1'b0;
         err_timeout      <= 1'b0;
         err_dims         <= 1'b0;
      end else begin
         load_config_done <= 1'b0;
         if (expire) begin
            state          <= POLL;
            mapped_address <= STARTSIG_ADDR;
            err_timeout    <= 1'b1;
            w              <= '0;
            sh_width       <= '0;
            sh_height      <= '0;
            sh_src         <= '0;
            sh_res         <= '0;
            sh_filt        <= '0;
         end else begin
            case (state)
               POLL: begin
                  if (mapped_data_valid && mapped_data[0]) begin
                     state          <= DIMS;
                     mapped_address <= DIMS_ADDR;
                  end
               end
               DIMS: begin
                  if (mapped_data_valid) begin
                     sh_width  <= mapped_data[31:16];
                     sh_height <= mapped_data[15:0];
                     if (mapped_data[31:16] == '0 || mapped_data[15:0] == '0) begin
                        err_dims       <= 1'b1;
                        state          <= CLEAR;
                        mapped_address <= STARTSIG_ADDR;
                     end else begin
                        state          <= SRC;
                        mapped_address <= SRC_ADDR;
                     end
                  end
               end
               SRC: begin
                  if (mapped_data_valid) begin
                     sh_src         <= mapped_data;
                     state          <= RES;
                     mapped_address <= RESULT_ADDR;
                  end
               end
               RES: begin
                  if (mapped_data_valid) begin
                     sh_res         <= mapped_data;
                     state          <= FILT;
                     w              <= '0;
                     mapped_address <= FILTER_ADDR;
                  end
               end
               FILT: begin
                  if (mapped_data_valid) begin
                     // Most significant byte is the lowest tap of the word;
                     // bytes past the last tap have no destination.
                     for (int unsigned t = 0; t < NT; t++) begin
                        if (WW'(t / 4) == w) begin
                           sh_filt[8*t +: 8] <= mapped_data[31 - 8*(t % 4) -: 8];
                        end
                     end
                     if (last_word) begin
                        state          <= DONE;
                        mapped_address <= STARTSIG_ADDR;
                     end else begin
                        w              <= w + WW'(1);
                        mapped_address <= FILTER_ADDR + ((32'(w) + 32'd1) << 2);
                     end
                  end
               end
               DONE: begin
                  image_width      <= sh_width;
                  image_height     <= sh_height;
                  start_address    <= sh_src;
                  result_address   <= sh_res;
                  filter           <= sh_filt;
                  load_config_done <= 1'b1;
                  err_timeout      <= 1'b0;
                  err_dims         <= 1'b0;
                  state            <= RUN;
               end
               RUN: begin
                  if (job_done) begin
                     state <= CLEAR;
                  end
               end
               CLEAR: begin
                  if (mapped_data_valid && !mapped_data[0]) begin
                     state <= POLL;
                  end
               end
               default: begin
                  state          <= POLL;
                  mapped_address <= STARTSIG_ADDR;
               end
            endcase
         end
      end
   end

endmodule
